// File: rtl/i2s_stereo_serializer.sv
// Stereo I2S / left-justified transmitter: a one-deep sample holding buffer
// feeds a frame register once per frame; bclk, lrck and dac are derived from clk.
module i2s_stereo_serializer #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_WIDTH   = 32,
    parameter int BCLK_DIV     = 4,
    parameter int I2S_MODE     = 1,
    parameter int SIGNED_IN    = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [SAMPLE_WIDTH-1:0] sample_l,
    input  logic [SAMPLE_WIDTH-1:0] sample_r,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    input  logic                    mute,
    output logic                    i2s_bclk,
    output logic                    i2s_lrck,
    output logic                    i2s_dac,
    output logic                    frame_start,
    output logic [15:0]             underflow_count
);

    localparam int FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int DIV_W      = $clog2(BCLK_DIV);
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int PAD        = SLOT_WIDTH - SAMPLE_WIDTH;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(BCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_EDGE = BIT_W'(SLOT_WIDTH);

    logic [DIV_W-1:0]        div_cnt_reg, div_cnt_next;
    logic [BIT_W-1:0]        bit_cnt_reg, bit_cnt_next;
    logic                    bclk_reg, bclk_next;
    logic                    lrck_reg, lrck_next;
    logic                    dac_reg, dac_next;
    logic                    ready_reg;
    logic                    hold_full_reg, hold_full_next;
    logic [15:0]             uf_reg, uf_next;
    logic [SAMPLE_WIDTH-1:0] sample_in  [2];
    logic [SAMPLE_WIDTH-1:0] hold_reg   [2];
    logic [SAMPLE_WIDTH-1:0] frame_reg  [2];
    logic [SAMPLE_WIDTH-1:0] frame_next [2];
    logic [SLOT_WIDTH-1:0]   slot_cur   [2];
    logic [SLOT_WIDTH-1:0]   slot_nxt   [2];
    logic [FRAME_BITS-1:0]   word_cur, word_nxt;
    logic                    bit_tick, load, transfer;

    assign sample_in[0] = sample_l;
    assign sample_in[1] = sample_r;

    // Offset-binary input becomes two's complement by flipping the MSB.
    function automatic logic [SAMPLE_WIDTH-1:0] to_frame(input logic [SAMPLE_WIDTH-1:0] s);
        logic [SAMPLE_WIDTH-1:0] r;
        r = s;
        if (SIGNED_IN == 0) r[SAMPLE_WIDTH-1] = ~s[SAMPLE_WIDTH-1];
        return r;
    endfunction

    // Each slot is the sample left-aligned, zero padded below the LSB.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            assign slot_cur[gi] = SLOT_WIDTH'(frame_reg[gi]) << PAD;
            assign slot_nxt[gi] = SLOT_WIDTH'(frame_next[gi]) << PAD;
        end
    endgenerate

    assign word_cur = {slot_cur[0], slot_cur[1]};
    assign word_nxt = {slot_nxt[0], slot_nxt[1]};

    always_comb begin
        bit_tick       = (div_cnt_reg == DIV_LAST);
        load           = bit_tick && (bit_cnt_reg == BIT_LAST);
        transfer       = sample_valid && ready_reg;
        div_cnt_next   = bit_tick ? '0 : div_cnt_reg + DIV_W'(1);
        bclk_next      = (div_cnt_next >= DIV_HALF);
        bit_cnt_next   = bit_cnt_reg;
        hold_full_next = hold_full_reg;
        uf_next        = uf_reg;
        lrck_next      = lrck_reg;
        dac_next       = dac_reg;
        for (int i = 0; i < 2; i++) frame_next[i] = frame_reg[i];

        if (bit_tick) bit_cnt_next = (bit_cnt_reg == BIT_LAST) ? '0 : bit_cnt_reg + BIT_W'(1);

        if (load) begin
            // A transfer landing on an empty-hold load fills hold for the next frame.
            hold_full_next = transfer;
            if (!hold_full_reg && uf_reg != 16'hFFFF) uf_next = uf_reg + 16'd1;
            for (int i = 0; i < 2; i++) begin
                if (mute)               frame_next[i] = '0;
                else if (hold_full_reg) frame_next[i] = to_frame(hold_reg[i]);
            end
        end else if (transfer) begin
            hold_full_next = 1'b1;
        end

        if (bit_tick) begin
            lrck_next = (bit_cnt_next >= SLOT_EDGE);
            if (I2S_MODE != 0) dac_next = word_cur[BIT_LAST - bit_cnt_reg];
            else               dac_next = word_nxt[BIT_LAST - bit_cnt_next];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_reg   <= '0;
            bit_cnt_reg   <= BIT_LAST;
            bclk_reg      <= 1'b0;
            lrck_reg      <= 1'b0;
            dac_reg       <= 1'b0;
            ready_reg     <= 1'b1;
            hold_full_reg <= 1'b0;
            uf_reg        <= '0;
            for (int i = 0; i < 2; i++) begin
                hold_reg[i]  <= '0;
                frame_reg[i] <= '0;
            end
        end else begin
            div_cnt_reg   <= div_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            bclk_reg      <= bclk_next;
            lrck_reg      <= lrck_next;
            dac_reg       <= dac_next;
            ready_reg     <= !hold_full_next;
            hold_full_reg <= hold_full_next;
            uf_reg        <= uf_next;
            for (int i = 0; i < 2; i++) begin
                frame_reg[i] <= frame_next[i];
                if (transfer) hold_reg[i] <= sample_in[i];
            end
        end
    end

    assign sample_ready    = ready_reg;
    assign i2s_bclk        = bclk_reg;
    assign i2s_lrck        = lrck_reg;
    assign i2s_dac         = dac_reg;
    assign frame_start     = load;
    assign underflow_count = uf_reg;

endmodule

// File: tb/tb_i2s_stereo_serializer.sv
// Bench for i2s_stereo_serializer: a frame-level reference model predicts every
// output each cycle; segment table, hand sequences and a second parameter set.
module tb_i2s_stereo_serializer;

    localparam int SW = 16, SL = 32, DIV = 4, NB = 2 * SL, FRAME = NB * DIV;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, sample_valid, sample_ready, mute;
    logic [15:0] sample_l, sample_r, underflow_count;
    logic        i2s_bclk, i2s_lrck, i2s_dac, frame_start;

    logic        rst2_n, valid2, ready2, bclk2, lrck2, dac2, fs2;
    logic [23:0] l2, r2;
    logic [15:0] uf2;

    i2s_stereo_serializer u_dut (
        .clk(clk), .reset_n(reset_n), .sample_l(sample_l), .sample_r(sample_r),
        .sample_valid(sample_valid), .sample_ready(sample_ready), .mute(mute),
        .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck), .i2s_dac(i2s_dac),
        .frame_start(frame_start), .underflow_count(underflow_count)
    );

    i2s_stereo_serializer #(
        .SAMPLE_WIDTH(24), .SLOT_WIDTH(32), .BCLK_DIV(2), .I2S_MODE(0), .SIGNED_IN(0)
    ) u_dut2 (
        .clk(clk), .reset_n(rst2_n), .sample_l(l2), .sample_r(r2),
        .sample_valid(valid2), .sample_ready(ready2), .mute(1'b0),
        .i2s_bclk(bclk2), .i2s_lrck(lrck2), .i2s_dac(dac2),
        .frame_start(fs2), .underflow_count(uf2)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: frame words as seen on the wire, bit 0 of a frame = word[NB-1].
    int          c;
    bit          m_hold_full;
    logic [15:0] m_hl, m_hr;
    logic [63:0] m_cur, m_prev;
    int          m_uf;

    function automatic logic [63:0] frame_word(input logic [15:0] l, input logic [15:0] r);
        return {l, 16'h0000, r, 16'h0000};
    endfunction

    task automatic model_reset();
        c = 0; m_hold_full = 0; m_hl = '0; m_hr = '0;
        m_cur = '0; m_prev = '0; m_uf = 0;
    endtask

    // Called at the negedge inside cycle c: drive inputs, compare, advance model.
    task automatic step(input bit v, input bit mu, input logic [15:0] l, input logic [15:0] r,
                        output bit accepted);
        logic [20:0] act, exp;
        logic e_lrck, e_dac;
        int b;
        sample_valid = v; mute = mu; sample_l = l; sample_r = r;
        e_lrck = 1'b0; e_dac = 1'b0;
        if (c >= DIV) begin
            b = ((c - DIV) / DIV) % NB;
            e_lrck = (b >= SL);
            e_dac  = (b > 0) ? m_cur[NB - b] : m_prev[0];
        end
        exp = {((c % DIV) >= DIV / 2), e_lrck, e_dac, ((c % FRAME) == DIV - 1),
               !m_hold_full, 16'(m_uf)};
        act = {i2s_bclk, i2s_lrck, i2s_dac, frame_start, sample_ready, underflow_count};
        check($sformatf("cycle%0d_outputs", c), 64'(act), 64'(exp));
        accepted = v && !m_hold_full;
        if ((c % FRAME) == DIV - 1) begin
            m_prev = m_cur;
            if (!m_hold_full) m_uf = (m_uf == 65535) ? 65535 : m_uf + 1;
            if (mu)               m_cur = '0;
            else if (m_hold_full) m_cur = frame_word(m_hl, m_hr);
            m_hold_full = accepted;
        end else if (accepted) begin
            m_hold_full = 1;
        end
        if (accepted) begin m_hl = l; m_hr = r; end
        c++;
        @(negedge clk);
    endtask

    typedef struct {
        int cycles;
        int valid_mode;   // 0 idle, 1 held with incrementing data, 2 random
        bit mute;
        int exp_uf;       // -1: only the model checks this segment
    } seg_t;

    seg_t        segs [6];
    logic [15:0] dl, dr;
    logic [63:0] cap_dac, cap_lr, cap2_dac, cap2_lr;
    logic [1:0]  cap2_bclk;
    logic [3:0]  cap2_fs;
    bit          acc, mu_r, found;
    int          b;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        segs[0] = '{1024, 1, 1'b0, 0};   // four frames, one pair consumed per frame
        segs[1] = '{1024, 0, 1'b0, 3};   // starved: held pair, then three underflows
        segs[2] = '{128,  1, 1'b0, 3};
        segs[3] = '{256,  1, 1'b1, 3};   // mute from mid-frame into the next frame
        segs[4] = '{256,  1, 1'b0, 3};
        segs[5] = '{2048, 2, 1'b0, -1};

        reset_n = 0; rst2_n = 0; sample_valid = 0; mute = 0;
        sample_l = '0; sample_r = '0; valid2 = 1; l2 = 24'h000000; r2 = 24'hFFFFFF;
        cap_dac = '0; cap_lr = '0; cap2_dac = '0; cap2_lr = '0; cap2_bclk = '0; cap2_fs = '0;
        repeat (3) @(negedge clk);
        check("reset_state", 64'({i2s_bclk, i2s_lrck, i2s_dac, frame_start, sample_ready, underflow_count}),
              64'({5'b00001, 16'h0000}));

        reset_n = 1;
        model_reset();
        dl = 16'h8001; dr = 16'h7FFE; mu_r = 0;
        for (int s = 0; s < 6; s++) begin
            for (int n = 0; n < segs[s].cycles; n++) begin
                if (c >= DIV && c < DIV + FRAME && (c % DIV) == 2) begin
                    b = (c - DIV) / DIV;
                    cap_dac[63 - b] = i2s_dac;
                    cap_lr[63 - b]  = i2s_lrck;
                end
                case (segs[s].valid_mode)
                    0: step(1'b0, segs[s].mute, dl, dr, acc);
                    1: begin
                        step(1'b1, segs[s].mute, dl, dr, acc);
                        if (acc) begin dl = dl + 16'd1; dr = dr + 16'd1; end
                    end
                    default: begin
                        if ($urandom_range(0, 199) == 0) mu_r = !mu_r;
                        step($urandom_range(0, 299) == 0, mu_r, 16'($urandom), 16'($urandom), acc);
                    end
                endcase
            end
            if (segs[s].exp_uf >= 0)
                check($sformatf("seg%0d_underflow", s), 64'(underflow_count), 64'(segs[s].exp_uf));
        end
        check("first_frame_dac", cap_dac, 64'h4000_8000_3FFF_0000);
        check("first_frame_lrck", cap_lr, 64'h0000_0000_FFFF_FFFF);

        // Async reset in the right slot with the hold buffer full.
        found = 0;
        for (int n = 0; n < 600 && !found; n++) begin
            if (c >= DIV && ((c - DIV) / DIV) % NB == 40 && m_hold_full) found = 1;
            else step(1'b1, 1'b0, dl, dr, acc);
        end
        check("reach_right_slot", 64'(found), 64'(1));
        #2 reset_n = 0;
        #1 check("async_reset", 64'({i2s_bclk, i2s_lrck, i2s_dac, frame_start, sample_ready, underflow_count}),
                 64'({5'b00001, 16'h0000}));
        sample_valid = 0;
        repeat (2) @(negedge clk);
        reset_n = 1;
        model_reset();

        // Transfer on the load cycle with an empty hold: underflow now, pair kept for next frame.
        repeat (3) step(1'b0, 1'b0, 16'h0, 16'h0, acc);
        step(1'b1, 1'b0, 16'h1234, 16'h5678, acc);
        check("same_cycle_underflow", 64'(underflow_count), 64'(1));
        check("same_cycle_ready", 64'(sample_ready), 64'(0));
        repeat (300) step(1'b0, 1'b0, 16'h0, 16'h0, acc);
        check("held_pair_loaded", 64'(underflow_count), 64'(1));

        // Offset-binary, 24-bit, divide-by-2, left-justified instance.
        rst2_n = 1;
        for (int k = 0; k < 132; k++) begin
            if (k < 4) cap2_fs[3 - k] = fs2;
            if (k == 2) cap2_bclk[1] = bclk2;
            if (k == 3) cap2_bclk[0] = bclk2;
            if (k >= 2 && (k % 2) == 0) begin
                cap2_dac[63 - (k - 2) / 2] = dac2;
                cap2_lr[63 - (k - 2) / 2]  = lrck2;
            end
            @(negedge clk);
        end
        check("p2_frame_start", 64'(cap2_fs), 64'(4'b0100));
        check("p2_bclk", 64'(cap2_bclk), 64'(2'b01));
        check("p2_dac", cap2_dac, 64'h8000_0000_7FFF_FF00);
        check("p2_lrck", cap2_lr, 64'h0000_0000_FFFF_FFFF);
        check("p2_underflow", 64'(uf2), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
